// File: rtl/qam_shaping_fir_if.sv
`default_nettype none
// ============================================================================
// Module      : qam_shaping_fir_if
// Description : Sample, coefficient-load and filtered-output signals of the
//               I/Q pulse-shaping filter, with source/sink modports.
// Revision    : 1.0 - initial release
// ============================================================================
interface qam_shaping_fir_if #(
  parameter int IN_W   = 32,
  parameter int COEF_W = 16,
  parameter int NTAPS  = 32,
  parameter int RATE_W = 2
);
  localparam int AW    = $clog2(NTAPS);
  localparam int ACC_W = IN_W + COEF_W + $clog2(NTAPS);

  logic                     enable;
  logic [RATE_W-1:0]        rate_sel;
  logic signed [IN_W-1:0]   in_i;
  logic signed [IN_W-1:0]   in_q;
  logic                     coef_we;
  logic [AW-1:0]            coef_addr;
  logic signed [COEF_W-1:0] coef_data;
  logic                     sample_stb;
  logic signed [ACC_W-1:0]  out_i;
  logic signed [ACC_W-1:0]  out_q;
  logic                     out_valid;

  modport master (
    output enable, rate_sel, in_i, in_q, coef_we, coef_addr, coef_data,
    input  sample_stb, out_i, out_q, out_valid
  );

  modport slave (
    input  enable, rate_sel, in_i, in_q, coef_we, coef_addr, coef_data,
    output sample_stb, out_i, out_q, out_valid
  );
endinterface
`default_nettype wire

// File: rtl/qam_shaping_fir.sv
`default_nettype none
// ============================================================================
// Module      : qam_shaping_fir
// Description : I/Q root-raised-cosine shaping FIR. Internal sample strobe
//               from a run-time rate select, shared coefficient RAM, one
//               time-multiplexed MAC per channel, bypass/hold mode.
// Revision    : 1.0 - initial release
// ============================================================================
module qam_shaping_fir #(
  parameter int IN_W     = 32,
  parameter int COEF_W   = 16,
  parameter int NTAPS    = 32,
  parameter int RATE_W   = 2,
  parameter int BASE_DIV = 40
) (
  input  logic             clk,
  input  logic             rst_n,
  qam_shaping_fir_if.slave bus
);
  localparam int AW     = $clog2(NTAPS);
  localparam int ACC_W  = IN_W + COEF_W + $clog2(NTAPS);
  localparam int PROD_W = IN_W + COEF_W;
  localparam int EXT_W  = ACC_W - PROD_W + 1;
  localparam int PMAX   = BASE_DIV << ((1 << RATE_W) - 1);
  localparam int CNT_W  = $clog2(PMAX + 1);
  localparam logic [RATE_W-1:0] RMAX    = '1;
  localparam logic [AW-1:0]     K_LAST  = AW'(NTAPS - 1);
  localparam logic [AW:0]       NTAPS_V = (AW+1)'(NTAPS);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                   state;
  state_t                   state_nxt;
  logic                     start;
  logic                     finish;

  logic [RATE_W-1:0]        rate_q;
  logic [CNT_W-1:0]         cnt;
  logic [CNT_W-1:0]         period;
  logic                     rate_chg;
  logic                     stb;
  logic                     abort;

  logic signed [IN_W-1:0]   dl_i [NTAPS];
  logic signed [IN_W-1:0]   dl_q [NTAPS];
  logic signed [COEF_W-1:0] coef [NTAPS];
  logic [AW-1:0]            k;
  logic signed [ACC_W-1:0]  acc_i;
  logic signed [ACC_W-1:0]  acc_q;
  logic signed [COEF_W-1:0] coef_k;
  logic signed [PROD_W-1:0] prod_i;
  logic signed [PROD_W-1:0] prod_q;

  logic signed [IN_W-1:0]   hold_i;
  logic signed [IN_W-1:0]   hold_q;
  logic                     byp_pend;
  logic signed [ACC_W-1:0]  byp_i;
  logic signed [ACC_W-1:0]  byp_q;
  logic signed [ACC_W-1:0]  out_i_reg;
  logic signed [ACC_W-1:0]  out_q_reg;
  logic                     out_valid_reg;

  // Sample period derives from the registered rate so a change restarts cleanly
  always_comb begin
    period   = CNT_W'(BASE_DIV) << (RMAX - rate_q);
    rate_chg = (bus.rate_sel != rate_q);
    stb      = (cnt == period - CNT_W'(1));
    abort    = rate_chg || !bus.enable;
  end

  // Period counter; a rate change restarts it from zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rate_q <= '0;
      cnt    <= '0;
    end else if (rate_chg) begin
      rate_q <= bus.rate_sel;
      cnt    <= '0;
    end else if (stb) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // FSM next state; rate change or bypass forces IDLE and kills any pass
  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    finish    = 1'b0;
    if (abort) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: if (stb) begin
          state_nxt = MAC;
          start     = 1'b1;
        end
        MAC:  if (k == K_LAST) state_nxt = DONE;
        DONE: begin
          state_nxt = IDLE;
          finish    = 1'b1;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // One tap per clock: both channels share the coefficient read at index k
  always_comb begin
    coef_k = coef[k];
    prod_i = PROD_W'(dl_i[k]) * PROD_W'(coef_k);
    prod_q = PROD_W'(dl_q[k]) * PROD_W'(coef_k);
  end

  // Delay lines, tap index and accumulators
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int t = 0; t < NTAPS; t++) begin
        dl_i[t] <= '0;
        dl_q[t] <= '0;
      end
      k     <= '0;
      acc_i <= '0;
      acc_q <= '0;
    end else if (abort) begin
      for (int t = 0; t < NTAPS; t++) begin
        dl_i[t] <= '0;
        dl_q[t] <= '0;
      end
    end else if (start) begin
      dl_i[0] <= bus.in_i;
      dl_q[0] <= bus.in_q;
      for (int t = 1; t < NTAPS; t++) begin
        dl_i[t] <= dl_i[t-1];
        dl_q[t] <= dl_q[t-1];
      end
      k     <= '0;
      acc_i <= '0;
      acc_q <= '0;
    end else if (state == MAC) begin
      acc_i <= acc_i + ACC_W'(prod_i);
      acc_q <= acc_q + ACC_W'(prod_q);
      if (k != K_LAST) k <= k + AW'(1);
    end
  end

  // Coefficient RAM; writes land in any state, out-of-range indices dropped
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int t = 0; t < NTAPS; t++) coef[t] <= '0;
    end else if (bus.coef_we && ({1'b0, bus.coef_addr} < NTAPS_V)) begin
      coef[bus.coef_addr] <= bus.coef_data;
    end
  end

  // Bypass output: held sample at unity gain in Q1.(COEF_W-1)
  assign byp_i = {{EXT_W{hold_i[IN_W-1]}}, hold_i, {(COEF_W-1){1'b0}}};
  assign byp_q = {{EXT_W{hold_q[IN_W-1]}}, hold_q, {(COEF_W-1){1'b0}}};

  // Hold capture and output registers for both filtered and bypass paths
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_i        <= '0;
      hold_q        <= '0;
      byp_pend      <= 1'b0;
      out_i_reg     <= '0;
      out_q_reg     <= '0;
      out_valid_reg <= 1'b0;
    end else begin
      out_valid_reg <= 1'b0;
      byp_pend      <= 1'b0;
      if (!rate_chg && !bus.enable && stb) begin
        byp_pend <= 1'b1;
        if (bus.in_i != '0) hold_i <= bus.in_i;
        if (bus.in_q != '0) hold_q <= bus.in_q;
      end
      if (byp_pend) begin
        out_i_reg     <= byp_i;
        out_q_reg     <= byp_q;
        out_valid_reg <= 1'b1;
      end else if (finish) begin
        out_i_reg     <= acc_i;
        out_q_reg     <= acc_q;
        out_valid_reg <= 1'b1;
      end
    end
  end

  assign bus.sample_stb = stb;
  assign bus.out_i      = out_i_reg;
  assign bus.out_q      = out_q_reg;
  assign bus.out_valid  = out_valid_reg;

endmodule
`default_nettype wire

// File: tb/tb_qam_shaping_fir.sv
`default_nettype none
// ============================================================================
// Module      : tb_qam_shaping_fir
// Description : Self-checking bench for qam_shaping_fir against a plain
//               convolution model of the filter and its bypass/hold rule.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_qam_shaping_fir;
  localparam int IN_W     = 32;
  localparam int COEF_W   = 16;
  localparam int NTAPS    = 32;
  localparam int RATE_W   = 2;
  localparam int BASE_DIV = 40;
  localparam int AW       = $clog2(NTAPS);
  localparam int ACC_W    = IN_W + COEF_W + $clog2(NTAPS);
  // Strobe cycle to out_valid cycle: strobe edge E0, output edge E(NTAPS+1),
  // pulse visible in the cycle after that edge.
  localparam int LAT      = NTAPS + 2;
  localparam int BYP_LAT  = 2;
  localparam int BUDGET   = 400;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_pass   = 0;

  longint m_coef [NTAPS];
  longint m_hi   [NTAPS];
  longint m_hq   [NTAPS];

  always #5 clk = ~clk;

  qam_shaping_fir_if #(.IN_W(IN_W), .COEF_W(COEF_W), .NTAPS(NTAPS), .RATE_W(RATE_W)) bus ();

  qam_shaping_fir #(
    .IN_W(IN_W), .COEF_W(COEF_W), .NTAPS(NTAPS), .RATE_W(RATE_W), .BASE_DIV(BASE_DIV)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  function automatic int period_of(input int r);
    return BASE_DIV * (1 << ((1 << RATE_W) - 1 - r));
  endfunction

  function automatic void m_clear();
    for (int k = 0; k < NTAPS; k++) begin
      m_hi[k] = 0;
      m_hq[k] = 0;
    end
  endfunction

  function automatic void m_push(input longint si, input longint sq);
    for (int k = NTAPS - 1; k > 0; k--) begin
      m_hi[k] = m_hi[k-1];
      m_hq[k] = m_hq[k-1];
    end
    m_hi[0] = si;
    m_hq[0] = sq;
  endfunction

  function automatic longint m_dot(input bit use_q);
    longint s = 0;
    for (int k = 0; k < NTAPS; k++) s += (use_q ? m_hq[k] : m_hi[k]) * m_coef[k];
    return s;
  endfunction

  task automatic write_coef(input int a, input longint v);
    @(negedge clk);
    bus.coef_we   = 1'b1;
    bus.coef_addr = AW'(a);
    bus.coef_data = COEF_W'(v);
    @(negedge clk);
    bus.coef_we   = 1'b0;
    m_coef[a] = v;
  endtask

  task automatic count_to_stb(output int n, output bit saw_valid);
    n = 0;
    saw_valid = 1'b0;
    do begin
      @(negedge clk);
      n++;
      if (bus.out_valid === 1'b1) saw_valid = 1'b1;
    end while (bus.sample_stb !== 1'b1 && n < BUDGET);
  endtask

  // Waits for the next strobe, presents a sample in that cycle, waits for out_valid.
  task automatic drive_sample(input logic signed [IN_W-1:0] si, input logic signed [IN_W-1:0] sq,
                              output logic signed [ACC_W-1:0] oi, output logic signed [ACC_W-1:0] oq,
                              output int wait_n, output int lat, output bit early, output bit ok);
    int n;
    ok = 1'b0; oi = '0; oq = '0; lat = 0;
    count_to_stb(wait_n, early);
    if (bus.sample_stb !== 1'b1) return;
    bus.in_i = si;
    bus.in_q = sq;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bus.out_valid !== 1'b1 && n < BUDGET);
    if (bus.out_valid === 1'b1) begin
      ok  = 1'b1;
      lat = n;
      oi  = bus.out_i;
      oq  = bus.out_q;
    end
  endtask

  task automatic test_reset();
    int n; bit sv;
    bus.enable = 1'b0; bus.rate_sel = '0; bus.in_i = '0; bus.in_q = '0;
    bus.coef_we = 1'b0; bus.coef_addr = '0; bus.coef_data = '0;
    repeat (3) @(negedge clk);
    n_checks++; if (bus.out_i !== '0) $display("FAIL reset_out_i: got %0d expected 0", bus.out_i); else n_pass++;
    n_checks++; if (bus.out_q !== '0) $display("FAIL reset_out_q: got %0d expected 0", bus.out_q); else n_pass++;
    n_checks++; if (bus.out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b expected 0", bus.out_valid); else n_pass++;
    n_checks++; if (bus.sample_stb !== 1'b0) $display("FAIL reset_stb: got %b expected 0", bus.sample_stb); else n_pass++;
    rst_n = 1'b1;
    count_to_stb(n, sv);
    n_checks++; if (n !== period_of(0) - 1) $display("FAIL reset_first_stb: got %0d expected %0d", n, period_of(0) - 1); else n_pass++;
  endtask

  task automatic test_impulse();
    logic signed [ACC_W-1:0] oi, oq, exp;
    int wn, lat; bit early, ok;
    bus.enable = 1'b0;
    bus.rate_sel = 2'd3;
    for (int k = 0; k < NTAPS; k++) write_coef(k, longint'(k + 1));
    @(negedge clk);
    bus.enable = 1'b1;
    m_clear();
    for (int n = 0; n <= NTAPS; n++) begin
      drive_sample((n == 0) ? 32'sd1 : 32'sd0, 32'sd0, oi, oq, wn, lat, early, ok);
      exp = (n < NTAPS) ? ACC_W'(n + 1) : '0;
      n_checks++; if (!ok) $display("FAIL impulse_valid[%0d]: got none expected out_valid", n); else n_pass++;
      n_checks++; if (oi !== exp) $display("FAIL impulse_i[%0d]: got %0d expected %0d", n, oi, exp); else n_pass++;
      n_checks++; if (oq !== '0) $display("FAIL impulse_q[%0d]: got %0d expected 0", n, oq); else n_pass++;
      if (n > 0) begin
        n_checks++;
        if (wn + lat !== BASE_DIV) $display("FAIL impulse_spacing[%0d]: got %0d expected %0d", n, wn + lat, BASE_DIV);
        else n_pass++;
      end
    end
  endtask

  task automatic test_rate_periods();
    logic signed [ACC_W-1:0] oi, oq, exp;
    logic signed [IN_W-1:0] si;
    int wn, lat, n; bit early, ok, sv;
    for (int r = 0; r < 4; r++) begin
      @(negedge clk);
      bus.rate_sel = RATE_W'(r);
      m_clear();
      si = $urandom();
      drive_sample(si, -si, oi, oq, wn, lat, early, ok);
      m_push(si, -si);
      exp = ACC_W'(m_dot(1'b0));
      n_checks++; if (wn !== period_of(r)) $display("FAIL rate%0d_first_stb: got %0d expected %0d", r, wn, period_of(r)); else n_pass++;
      n_checks++; if (lat !== LAT) $display("FAIL rate%0d_latency: got %0d expected %0d", r, lat, LAT); else n_pass++;
      n_checks++; if (oi !== exp) $display("FAIL rate%0d_out_i: got %0d expected %0d", r, oi, exp); else n_pass++;
      count_to_stb(n, sv);
      count_to_stb(n, sv);
      n_checks++; if (n !== period_of(r)) $display("FAIL rate%0d_period: got %0d expected %0d", r, n, period_of(r)); else n_pass++;
    end
  endtask

  task automatic test_rate_change();
    logic signed [ACC_W-1:0] oi, oq, exp;
    int wn, lat, n; bit early, ok, sv;
    bus.enable = 1'b0;
    for (int k = 0; k < NTAPS; k++) write_coef(k, (k < 2) ? 64'sd1 : 64'sd0);
    @(negedge clk);
    bus.enable = 1'b1;
    m_clear();
    for (int s = 0; s < 3; s++) begin
      drive_sample(32'sd1000, 32'sd0, oi, oq, wn, lat, early, ok);
      m_push(1000, 0);
      exp = ACC_W'(m_dot(1'b0));
      n_checks++; if (oi !== exp) $display("FAIL dc_pre[%0d]: got %0d expected %0d", s, oi, exp); else n_pass++;
    end
    count_to_stb(n, sv);
    repeat (5) @(negedge clk);
    bus.rate_sel = 2'd1;
    m_clear();
    for (int s = 0; s < 2; s++) begin
      drive_sample(32'sd1000, 32'sd0, oi, oq, wn, lat, early, ok);
      m_push(1000, 0);
      exp = ACC_W'(m_dot(1'b0));
      if (s == 0) begin
        n_checks++; if (wn !== period_of(1)) $display("FAIL rchg_first_stb: got %0d expected %0d", wn, period_of(1)); else n_pass++;
        n_checks++; if (early !== 1'b0) $display("FAIL rchg_aborted_valid: got %b expected 0", early); else n_pass++;
      end
      n_checks++; if (oi !== exp) $display("FAIL rchg_out_i[%0d]: got %0d expected %0d", s, oi, exp); else n_pass++;
    end
  endtask

  task automatic test_bypass();
    logic signed [ACC_W-1:0] oi, oq, exp_i, exp_q;
    int bi [3];
    int bq [3];
    longint hi, hq;
    int wn, lat, n; bit early, ok, sv;
    bi = '{32'h0000_1234, 0, 32'hFFFF_FFFE};
    bq = '{-5, 0, 0};
    @(negedge clk);
    bus.rate_sel = 2'd3;
    count_to_stb(n, sv);
    repeat (5) @(negedge clk);
    bus.enable = 1'b0;
    hi = longint'(dut.hold_i);
    hq = longint'(dut.hold_q);
    for (int s = 0; s < 3; s++) begin
      drive_sample(IN_W'(bi[s]), IN_W'(bq[s]), oi, oq, wn, lat, early, ok);
      if (bi[s] != 0) hi = bi[s];
      if (bq[s] != 0) hq = bq[s];
      exp_i = ACC_W'(hi * 32768);
      exp_q = ACC_W'(hq * 32768);
      if (s == 0) begin
        n_checks++; if (early !== 1'b0) $display("FAIL bypass_abort_valid: got %b expected 0", early); else n_pass++;
      end
      n_checks++; if (lat !== BYP_LAT) $display("FAIL bypass_latency[%0d]: got %0d expected %0d", s, lat, BYP_LAT); else n_pass++;
      n_checks++; if (oi !== exp_i) $display("FAIL bypass_i[%0d]: got %0d expected %0d", s, oi, exp_i); else n_pass++;
      n_checks++; if (oq !== exp_q) $display("FAIL bypass_q[%0d]: got %0d expected %0d", s, oq, exp_q); else n_pass++;
    end
  endtask

  task automatic test_full_scale();
    logic signed [ACC_W-1:0] oi, oq, exp;
    int wn, lat; bit early, ok;
    bus.enable = 1'b0;
    for (int k = 0; k < NTAPS; k++) write_coef(k, -64'sd32768);
    @(negedge clk);
    bus.enable = 1'b1;
    m_clear();
    for (int s = 0; s < NTAPS; s++) begin
      drive_sample(32'sh8000_0000, 32'sh8000_0000, oi, oq, wn, lat, early, ok);
      m_push(-64'sd2147483648, -64'sd2147483648);
      exp = ACC_W'(m_dot(1'b0));
      n_checks++; if (oi !== exp) $display("FAIL fullscale_i[%0d]: got %0d expected %0d", s, oi, exp); else n_pass++;
      n_checks++; if (oq !== exp) $display("FAIL fullscale_q[%0d]: got %0d expected %0d", s, oq, exp); else n_pass++;
    end
    exp = ACC_W'(64'sd1 << 51);
    n_checks++; if (oi !== exp) $display("FAIL fullscale_final: got %0d expected %0d", oi, exp); else n_pass++;
  endtask

  task automatic test_random();
    logic signed [ACC_W-1:0] oi, oq, exp_i, exp_q;
    logic signed [IN_W-1:0] si, sq;
    int wn, lat; bit early, ok;
    bus.enable = 1'b0;
    for (int k = 0; k < NTAPS; k++) write_coef(k, longint'($signed(16'($urandom()))));
    @(negedge clk);
    bus.enable = 1'b1;
    m_clear();
    for (int s = 0; s < 24; s++) begin
      si = $urandom();
      sq = $urandom();
      drive_sample(si, sq, oi, oq, wn, lat, early, ok);
      m_push(si, sq);
      exp_i = ACC_W'(m_dot(1'b0));
      exp_q = ACC_W'(m_dot(1'b1));
      n_checks++; if (oi !== exp_i) $display("FAIL random_i[%0d]: got %0d expected %0d", s, oi, exp_i); else n_pass++;
      n_checks++; if (oq !== exp_q) $display("FAIL random_q[%0d]: got %0d expected %0d", s, oq, exp_q); else n_pass++;
      write_coef(int'($urandom_range(0, NTAPS - 1)), longint'($signed(16'($urandom()))));
    end
  endtask

  task automatic test_async_reset();
    logic signed [ACC_W-1:0] oi, oq;
    int wn, lat, n; bit early, ok, sv;
    count_to_stb(n, sv);
    repeat (10) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if (bus.out_i !== '0) $display("FAIL arst_out_i: got %0d expected 0", bus.out_i); else n_pass++;
    n_checks++; if (bus.out_q !== '0) $display("FAIL arst_out_q: got %0d expected 0", bus.out_q); else n_pass++;
    n_checks++; if (bus.out_valid !== 1'b0) $display("FAIL arst_out_valid: got %b expected 0", bus.out_valid); else n_pass++;
    n_checks++; if (bus.sample_stb !== 1'b0) $display("FAIL arst_stb: got %b expected 0", bus.sample_stb); else n_pass++;
    bus.rate_sel = '0;
    for (int k = 0; k < NTAPS; k++) m_coef[k] = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    count_to_stb(n, sv);
    n_checks++; if (n !== period_of(0) - 1) $display("FAIL arst_first_stb: got %0d expected %0d", n, period_of(0) - 1); else n_pass++;
    n_checks++; if (sv !== 1'b0) $display("FAIL arst_stale_valid: got %b expected 0", sv); else n_pass++;
    drive_sample(32'sh7FFF_FFFF, 32'sh7FFF_FFFF, oi, oq, wn, lat, early, ok);
    n_checks++; if (!ok) $display("FAIL arst_post_valid: got none expected out_valid"); else n_pass++;
    n_checks++; if (oi !== ACC_W'(m_dot(1'b0))) $display("FAIL arst_coef_cleared: got %0d expected 0", oi); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_impulse();
    test_rate_periods();
    test_rate_change();
    test_bypass();
    test_full_scale();
    test_random();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion expected finish within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
